jb_aes_mode_ctrl: RTL and testbench

Multi-block, mode-aware sequencer for single-block AES cores. It accepts a stream of BLOCK_WIDTH-bit blocks and applies ECB, CBC (encrypt or decrypt) or CTR chaining. It drives an external single-block cipher core through a start/done pulse handshake and returns results on a ready/valid output stream. It sits between the packet datapath and the encrypt/decrypt cores, adding chaining, IV/counter state and flow control that the bare cores lack.

---
 rtl/jb_aes_mode_ctrl.sv | 168 ++++++++++++++++
 tb/tb_jb_aes_mode_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_aes_mode_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jb_aes_mode_ctrl : ECB/CBC/CTR chaining sequencer for a single-block AES core
// Revision 1.0
// ----------------------------------------------------------------------------
module jb_aes_mode_ctrl #(
  parameter int BLOCK_WIDTH = 128,
  parameter int CTR_WIDTH   = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [1:0]             cfg_mode_i,
  input  logic                   cfg_dir_i,
  input  logic [BLOCK_WIDTH-1:0] cfg_iv_i,
  output logic                   cfg_err_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [BLOCK_WIDTH-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [BLOCK_WIDTH-1:0] out_data_o,
  output logic                   core_start_o,
  output logic                   core_dir_o,
  output logic [BLOCK_WIDTH-1:0] core_in_o,
  input  logic                   core_done_i,
  input  logic [BLOCK_WIDTH-1:0] core_out_i,
  output logic [CNT_WIDTH-1:0]   blk_count_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // Only the low CTR_WIDTH bits of the counter block advance; upper bits are fixed.
  localparam logic [BLOCK_WIDTH-1:0] CTR_MASK = BLOCK_WIDTH'({CTR_WIDTH{1'b1}});

  logic [1:0]             state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic                   dir_q, dir_d;
  logic                   loaded_q, loaded_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [BLOCK_WIDTH-1:0] chain_q, chain_d;
  logic [BLOCK_WIDTH-1:0] save_q, save_d;
  logic [BLOCK_WIDTH-1:0] core_in_q, core_in_d;
  logic [BLOCK_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic w_idle;
  logic w_cfg_take;
  logic w_in_take;

  assign w_idle     = (state_q == ST_IDLE);
  assign w_cfg_take = w_idle && cfg_valid_i;
  assign w_in_take  = w_idle && loaded_q && !cfg_valid_i && in_valid_i;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    loaded_d   = loaded_q;
    cfg_err_d  = 1'b0;
    chain_d    = chain_q;
    save_d     = save_q;
    core_in_d  = core_in_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_cfg_take) begin
          if (cfg_mode_i == MODE_RSV) begin
            cfg_err_d = 1'b1;
          end else begin
            mode_d   = cfg_mode_i;
            dir_d    = cfg_dir_i;
            chain_d  = cfg_iv_i;
            cnt_d    = '0;
            loaded_d = 1'b1;
          end
        end else if (w_in_take) begin
          state_d = ST_START;
          save_d  = in_data_i;
          case (mode_q)
            MODE_CBC: core_in_d = dir_q ? in_data_i : (in_data_i ^ chain_q);
            MODE_CTR: core_in_d = chain_q;
            default:  core_in_d = in_data_i;
          endcase
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done_i) begin
          state_d = ST_OUT;
          case (mode_q)
            MODE_CBC: begin
              if (dir_q) begin
                out_data_d = core_out_i ^ chain_q;
                chain_d    = save_q;
              end else begin
                out_data_d = core_out_i;
                chain_d    = core_out_i;
              end
            end
            MODE_CTR: begin
              out_data_d = save_q ^ core_out_i;
              chain_d    = (chain_q & ~CTR_MASK) | ((chain_q + BLOCK_WIDTH'(1)) & CTR_MASK);
            end
            default: out_data_d = core_out_i;
          endcase
        end
      end
      ST_OUT: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ECB;
      dir_q      <= 1'b0;
      loaded_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
      chain_q    <= '0;
      save_q     <= '0;
      core_in_q  <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      loaded_q   <= loaded_d;
      cfg_err_q  <= cfg_err_d;
      chain_q    <= chain_d;
      save_q     <= save_d;
      core_in_q  <= core_in_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cfg_ready_o  = w_idle;
  assign cfg_err_o    = cfg_err_q;
  assign in_ready_o   = w_idle && loaded_q && !cfg_valid_i;
  assign out_valid_o  = (state_q == ST_OUT);
  assign out_data_o   = out_data_q;
  assign core_start_o = (state_q == ST_START);
  // Counter mode always runs the core forward, whatever direction was configured.
  assign core_dir_o   = dir_q && (mode_q != MODE_CTR);
  assign core_in_o    = core_in_q;
  assign blk_count_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_jb_aes_mode_ctrl.sv
`default_nettype none
// tb_jb_aes_mode_ctrl : directed bench with a block-level chaining model and a
// 3-cycle XOR stand-in for the cipher core.
module tb_jb_aes_mode_ctrl;
  localparam int BW = 128;
  localparam int CW = 32;
  localparam int NW = 16;
  localparam logic [BW-1:0] CORE_KEY = 128'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_mode = 2'b00;
  logic          cfg_dir = 1'b0;
  logic [BW-1:0] cfg_iv = '0;
  logic          cfg_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic          core_start;
  logic          core_dir;
  logic [BW-1:0] core_in;
  logic          core_done = 1'b0;
  logic [BW-1:0] core_out = '0;
  logic [NW-1:0] blk_count;

  jb_aes_mode_ctrl #(.BLOCK_WIDTH(BW), .CTR_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_mode_i(cfg_mode),
    .cfg_dir_i(cfg_dir), .cfg_iv_i(cfg_iv), .cfg_err_o(cfg_err),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .core_start_o(core_start), .core_dir_o(core_dir), .core_in_o(core_in),
    .core_done_i(core_done), .core_out_i(core_out), .blk_count_o(blk_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // Core stand-in: done pulses 3 cycles after the start cycle with core_in ^ A5.
  int            core_cnt = 0;
  logic [BW-1:0] core_hold = '0;
  initial begin
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done = 1'b1;
          core_out  = core_hold ^ CORE_KEY;
        end
      end
      if (core_start === 1'b1) begin
        core_cnt  = 3;
        core_hold = core_in;
      end
    end
  end

  // Block-level model of what each accepted block must produce.
  logic [1:0]    m_mode = 2'b00;
  logic          m_dir = 1'b0;
  logic [BW-1:0] m_chain = '0;
  logic [NW-1:0] m_cnt = '0;
  logic [BW-1:0] exp_ci[$];
  logic          exp_dir[$];
  logic [BW-1:0] exp_out[$];

  task automatic model_accept(input logic [BW-1:0] d);
    logic [BW-1:0] ci, o;
    case (m_mode)
      2'b00: begin ci = d; o = d ^ CORE_KEY; end
      2'b01: begin
        if (!m_dir) begin ci = d ^ m_chain; o = ci ^ CORE_KEY; m_chain = o; end
        else begin ci = d; o = (d ^ CORE_KEY) ^ m_chain; m_chain = d; end
      end
      default: begin
        ci = m_chain;
        o  = d ^ m_chain ^ CORE_KEY;
        m_chain = {m_chain[BW-1:CW], m_chain[CW-1:0] + CW'(1)};
      end
    endcase
    exp_ci.push_back(ci);
    exp_dir.push_back((m_mode == 2'b10) ? 1'b0 : m_dir);
    exp_out.push_back(o);
  endtask

  logic          err_pend = 1'b0;
  logic          ov_prev = 1'b0;
  int            start_cyc = 0, done_cyc = 0, ov_rise_cyc = 0, acc_cyc = 0;
  logic [BW-1:0] last_ci = '0;
  logic          last_dir = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_ci.delete(); exp_dir.delete(); exp_out.delete();
      m_cnt = '0; err_pend = 1'b0; ov_prev = 1'b0;
    end else begin
      chk("cfg_err", cfg_err, err_pend);
      chk("blk_count", blk_count, m_cnt);
      if (core_done) done_cyc = cyc;
      if (core_start) begin
        start_cyc = cyc; last_ci = core_in; last_dir = core_dir;
        if (exp_ci.size() == 0) fail_now("unexpected_core_start");
        else begin
          chk("core_in", core_in, exp_ci.pop_front());
          chk("core_dir", core_dir, exp_dir.pop_front());
        end
      end
      if (out_valid) begin
        if (!ov_prev) ov_rise_cyc = cyc;
        chk("in_ready_during_out", in_ready, 1'b0);
        if (exp_out.size() == 0) fail_now("unexpected_out_valid");
        else begin
          chk("out_data", out_data, exp_out[0]);
          if (out_ready) begin
            void'(exp_out.pop_front());
            m_cnt = m_cnt + NW'(1);
          end
        end
      end
      ov_prev  = out_valid;
      err_pend = cfg_valid && cfg_ready && (cfg_mode == 2'b11);
      if (cfg_valid && cfg_ready && (cfg_mode != 2'b11)) m_cnt = '0;
    end
  end

  // Tasks below start and end just after a rising edge.
  task automatic configure(input logic [1:0] m, input logic d, input logic [BW-1:0] iv);
    int t = 0;
    cfg_valid = 1'b1; cfg_mode = m; cfg_dir = d; cfg_iv = iv;
    @(negedge clk);
    while (cfg_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (cfg_ready !== 1'b1) fail_now("cfg_ready_timeout");
    if (m != 2'b11) begin m_mode = m; m_dir = d; m_chain = iv; end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [BW-1:0] d);
    int t = 0;
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (in_ready !== 1'b1) fail_now("in_ready_timeout");
    else begin acc_cyc = cyc; model_accept(d); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [BW-1:0] lit);
    int t = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (out_valid !== 1'b1) fail_now({name, "_timeout"});
    else begin
      chk(name, out_data, lit);
      @(negedge clk);
      chk({name, "_in_ready_next"}, in_ready, 1'b1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] hold_d;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_core_dir", core_dir, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_core_in", core_in, '0);
    chk("rst_blk_count", blk_count, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // ECB with latency checks
    configure(2'b00, 1'b0, '0);
    send(128'h52);
    expect_out("ecb_out", 128'hF7);
    chk("ecb_start_latency", start_cyc, acc_cyc + 1);
    chk("ecb_out_latency", ov_rise_cyc, done_cyc + 1);
    chk("ecb_blk_count", blk_count, 1);

    // CBC encrypt
    configure(2'b01, 1'b0, 128'h01);
    send(128'h10);
    expect_out("cbc_enc_out0", 128'hB4);
    send(128'h20);
    expect_out("cbc_enc_out1", 128'h31);
    chk("cbc_enc_core_in1", last_ci, 128'h94);

    // CBC decrypt
    configure(2'b01, 1'b1, 128'h01);
    send(128'hB4);
    expect_out("cbc_dec_out0", 128'h10);
    send(128'h31);
    expect_out("cbc_dec_out1", 128'h20);
    chk("cbc_dec_core_dir", last_dir, 1'b1);

    // CTR low-word wrap without carry into upper bits
    configure(2'b10, 1'b1, 128'h1_FFFFFFFF);
    send('0);
    expect_out("ctr_out0", 128'h1_FFFFFF5A);
    send('0);
    expect_out("ctr_out1", 128'h1_000000A5);
    chk("ctr_core_dir", last_dir, 1'b0);
    chk("ctr_blk_count", blk_count, 2);

    // Output back-pressure
    configure(2'b00, 1'b0, '0);
    out_ready = 1'b0;
    send(128'h33);
    begin
      int t = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    end
    hold_d = out_data;
    chk("hold_data_value", hold_d, 128'h96);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_out_data", out_data, hold_d);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    // Config beats a simultaneous input
    cfg_valid = 1'b1; cfg_mode = 2'b10; cfg_dir = 1'b0; cfg_iv = 128'h77;
    in_valid = 1'b1; in_data = 128'h55;
    @(negedge clk);
    chk("prio_in_ready", in_ready, 1'b0);
    m_mode = 2'b10; m_dir = 1'b0; m_chain = 128'h77;
    @(posedge clk); #1;
    cfg_valid = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("prio_no_start", core_start, 1'b0);
    end
    @(posedge clk); #1;
    send(128'h55);
    expect_out("prio_ctr_out", 128'h87);

    // Reserved mode: error pulse, previous config kept
    cfg_valid = 1'b1; cfg_mode = 2'b11; cfg_dir = 1'b1; cfg_iv = '1;
    @(negedge clk);
    chk("rsv_err_same_cycle", cfg_err, 1'b0);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("rsv_err_pulse", cfg_err, 1'b1);
    @(negedge clk);
    chk("rsv_err_clear", cfg_err, 1'b0);
    @(posedge clk); #1;
    send(128'h55);
    expect_out("rsv_keeps_ctr", 128'h88);
    chk("rsv_blk_count", blk_count, 2);

    // Reset while waiting on the core
    configure(2'b00, 1'b0, '0);
    send(128'h52);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; in_data = 128'h01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rstwait_out_valid", out_valid, 1'b0);
      chk("rstwait_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    configure(2'b00, 1'b0, '0);
    send(128'h10);
    expect_out("rstwait_recover", 128'hB5);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
